// File: rtl/nibble_share_arb.sv
// rtl/nibble_share_arb.sv - two-requester arbiter for the shared 4-bit LED bank
//
// Purpose:
//   Grants the LED bank to one of two nibble sources. Arbitration is round-robin
//   with a minimum dwell per grant. A debounced pushbutton toggles a freeze mode
//   that pins the current owner until the button is pressed again.
//
// Configuration macro:
//   NIBBLE_ARB_FIXED_PRIO_EN - when defined, requester 0 has fixed priority:
//   it wins ties from IDLE and can preempt requester 1 after dwell. Requester 1
//   never preempts requester 0. When undefined, arbitration is round-robin.
//
// Parameters:
//   DWELL     - minimum cycles a grant is held while the other side waits (>= 1)
//   DB_CYCLES - consecutive stable pba samples needed to accept a level (>= 1)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   req    in   [1:0] request lines, bit n = requester n
//   nib0   in   [3:0] nibble of requester 0
//   nib1   in   [3:0] nibble of requester 1
//   pba    in   raw pushbutton, asynchronous and bouncy
//   led    out  [3:0] registered nibble of the current owner, 0 when idle
//   gnt    out  [1:0] one-hot grant, 2'b00 when idle
//   frozen out  freeze mode active

module nibble_share_arb #(
    parameter int DWELL     = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] nib0,
    input  logic [3:0] nib1,
    input  logic       pba,
    output logic [3:0] led,
    output logic [1:0] gnt,
    output logic       frozen
);

    localparam int CW = $clog2(DWELL) + 1;
    localparam int DW = $clog2(DB_CYCLES) + 1;

    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          ptr;       // last requester granted
    logic          ptr_nx;
    logic [3:0]    led_nx;

    // Whether the owner may be taken over once its dwell has expired.
    logic          preempt0;
    logic          preempt1;

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [DW-1:0] dbcnt;
    logic          db_flip;

    // ------------------------------------------------------------------
    // Arbitration policy
    // ------------------------------------------------------------------
`ifdef NIBBLE_ARB_FIXED_PRIO_EN
    assign preempt0 = 1'b0;
    assign preempt1 = 1'b1;
`else
    assign preempt0 = 1'b1;
    assign preempt1 = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Next-state, dwell counter, pointer and LED source
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        led_nx   = 4'h0;

        unique case (state)
            IDLE: begin
                unique case (req)
                    2'b01:   state_nx = OWN0;
                    2'b10:   state_nx = OWN1;
`ifdef NIBBLE_ARB_FIXED_PRIO_EN
                    2'b11:   state_nx = OWN0;
`else
                    2'b11:   state_nx = ptr ? OWN0 : OWN1;
`endif
                    default: state_nx = IDLE;
                endcase
            end
            OWN0: begin
                // Releasing the request always wins over dwell and freeze.
                if (!req[0]) begin
                    state_nx = req[1] ? OWN1 : IDLE;
                end else if ((cnt == '0) && req[1] && !frozen && preempt0) begin
                    state_nx = OWN1;
                end
            end
            OWN1: begin
                if (!req[1]) begin
                    state_nx = req[0] ? OWN0 : IDLE;
                end else if ((cnt == '0) && req[0] && !frozen && preempt1) begin
                    state_nx = OWN0;
                end
            end
            default: state_nx = IDLE;
        endcase

        // A new owner (from IDLE or from the other owner) restarts the dwell;
        // otherwise the counter runs down and rests at zero.
        if ((state_nx != state) && (state_nx != IDLE)) begin
            cnt_nx = DWELL_LOAD;
            ptr_nx = (state_nx == OWN1);
        end else if (cnt != '0) begin
            cnt_nx = cnt - CW'(1);
        end

        unique case (state_nx)
            OWN0:    led_nx = nib0;
            OWN1:    led_nx = nib1;
            default: led_nx = 4'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 1'b1;
            led   <= 4'h0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ptr   <= ptr_nx;
            led   <= led_nx;
        end
    end

    // gnt is a plain decode of the registered state, so it moves on the
    // same edge as led and can never show both bits.
    always_comb begin
        gnt = 2'b00;
        unique case (state)
            OWN0:    gnt = 2'b01;
            OWN1:    gnt = 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // Pushbutton synchronizer, debounce and freeze toggle
    // ------------------------------------------------------------------
    // The new level is accepted on the edge where the counter has already
    // seen DB_CYCLES-1 differing samples and the current one still differs.
    assign db_flip = (sync2 != stable) && (dbcnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            dbcnt  <= '0;
            frozen <= 1'b0;
        end else begin
            sync1 <= pba;
            sync2 <= sync1;
            if (sync2 == stable) begin
                dbcnt <= '0;
            end else if (db_flip) begin
                stable <= ~stable;
                dbcnt  <= '0;
                // Only a press (rising stable level) toggles freeze.
                if (!stable) begin
                    frozen <= ~frozen;
                end
            end else begin
                dbcnt <= dbcnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nibble_share_arb.sv
// tb/tb_nibble_share_arb.sv - directed vector bench for nibble_share_arb

module tb_nibble_share_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] nib0;
    logic [3:0] nib1;
    logic       pba;
    logic [3:0] led;
    logic [1:0] gnt;
    logic       frozen;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_share_arb #(
        .DWELL     (8),
        .DB_CYCLES (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .nib0   (nib0),
        .nib1   (nib1),
        .pba    (pba),
        .led    (led),
        .gnt    (gnt),
        .frozen (frozen)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [3:0] n0;
        logic [3:0] n1;
        logic       pba;
        logic [3:0] led;
        logic [1:0] gnt;
        logic       fr;
    } vec_t;

    vec_t vt[$];

    task automatic add(input int n, input logic r, input logic [1:0] rq,
                       input logic [3:0] a, input logic [3:0] b, input logic p,
                       input logic [3:0] l, input logic [1:0] g, input logic f);
        vec_t v;
        v.rst = r; v.req = rq; v.n0 = a; v.n1 = b; v.pba = p;
        v.led = l; v.gnt = g; v.fr = f;
        for (int i = 0; i < n; i++) vt.push_back(v);
    endtask

    task automatic check(input string nm, input int idx,
                         input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %h want %h", nm, idx, got, exp);
        end
    endtask

    task automatic step(input string nm, input int idx, input logic [3:0] eled,
                        input logic [1:0] egnt, input logic efr);
        @(posedge clk);
        #1;
        check({nm, ".led"}, idx, led, eled);
        check({nm, ".gnt"}, idx, {2'b00, gnt}, {2'b00, egnt});
        check({nm, ".frozen"}, idx, {3'b000, frozen}, {3'b000, efr});
    endtask

    initial begin
        logic [9:0] bounce;

        rst = 1'b1; req = 2'b00; nib0 = 4'h0; nib1 = 4'h0; pba = 1'b0;

        // rst  req    n0    n1    pba   led   gnt    fr
        add(2, 1, 2'b11, 4'hA, 4'h5, 1, 4'h0, 2'b00, 0);  // reset with req and button held
        add(8, 0, 2'b11, 4'hA, 4'h5, 0, 4'hA, 2'b01, 0);  // requester 0 wins first
        add(8, 0, 2'b11, 4'hA, 4'h5, 0, 4'h5, 2'b10, 0);
        add(8, 0, 2'b11, 4'hA, 4'h5, 0, 4'hA, 2'b01, 0);
        add(4, 0, 2'b11, 4'hA, 4'h5, 0, 4'h5, 2'b10, 0);
        add(4, 0, 2'b11, 4'hA, 4'h3, 0, 4'h3, 2'b10, 0);  // led follows owner nibble
        add(3, 0, 2'b11, 4'hA, 4'h3, 0, 4'hA, 2'b01, 0);
        add(1, 0, 2'b10, 4'hA, 4'h3, 0, 4'h3, 2'b10, 0);  // early release mid-dwell
        add(7, 0, 2'b11, 4'hA, 4'h3, 0, 4'h3, 2'b10, 0);  // reloaded dwell
        add(1, 0, 2'b11, 4'hA, 4'h3, 0, 4'hA, 2'b01, 0);
        add(1, 0, 2'b00, 4'hA, 4'h3, 0, 4'h0, 2'b00, 0);  // release to IDLE
        add(1, 0, 2'b11, 4'hA, 4'h3, 0, 4'h3, 2'b10, 0);  // pointer says 1
        add(1, 0, 2'b00, 4'hA, 4'h3, 0, 4'h0, 2'b00, 0);
        add(1, 0, 2'b01, 4'hA, 4'h3, 0, 4'hA, 2'b01, 0);
        add(1, 0, 2'b00, 4'hA, 4'h3, 0, 4'h0, 2'b00, 0);
        add(1, 0, 2'b10, 4'hA, 4'h3, 0, 4'h3, 2'b10, 0);
        add(1, 0, 2'b11, 4'hA, 4'h3, 0, 4'h3, 2'b10, 0);
        add(1, 0, 2'b01, 4'hA, 4'h3, 0, 4'hA, 2'b01, 0);  // direct OWN1 -> OWN0
        add(12, 0, 2'b01, 4'hA, 4'h3, 0, 4'hA, 2'b01, 0); // lone requester keeps grant
        add(1, 0, 2'b00, 4'hA, 4'h3, 0, 4'h0, 2'b00, 0);

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; req = vt[i].req; nib0 = vt[i].n0;
            nib1 = vt[i].n1; pba = vt[i].pba;
            step("vec", i, vt[i].led, vt[i].gnt, vt[i].fr);
        end

        // Freeze press with bounce while owner 1 is alone, then contention.
        req = 2'b10;
        step("frz_own1", 0, 4'h3, 2'b10, 1'b0);
        bounce = 10'b11_1111_1101;   // bit j drives cycle j: 1,0,1,1,...
        for (int j = 0; j < 10; j++) begin
            pba = bounce[j];
            step("frz_press", j, 4'h3, 2'b10, (j >= 7));
        end
        pba = 1'b0;
        req = 2'b11;
        for (int j = 0; j < 50; j++) step("frz_hold", j, 4'h3, 2'b10, 1'b1);

        // Second press unfreezes; the waiting requester takes over next edge.
        pba = 1'b1;
        for (int j = 0; j < 6; j++) step("unfrz_press", j, 4'h3, 2'b10, (j < 5));
        pba = 1'b0;
        step("unfrz_switch", 0, 4'hA, 2'b01, 1'b0);

        // Short glitch must not register as a press.
        req = 2'b01;
        for (int j = 0; j < 8; j++) step("settle", j, 4'hA, 2'b01, 1'b0);
        pba = 1'b1;
        for (int j = 0; j < 3; j++) step("glitch", j, 4'hA, 2'b01, 1'b0);
        pba = 1'b0;
        for (int j = 0; j < 8; j++) step("glitch_after", j, 4'hA, 2'b01, 1'b0);

        // Reset while owner 1 holds the bank frozen.
        req = 2'b10;
        step("rm_own1", 0, 4'h3, 2'b10, 1'b0);
        pba = 1'b1;
        for (int j = 0; j < 6; j++) step("rm_press", j, 4'h3, 2'b10, (j == 5));
        rst = 1'b1; req = 2'b11; pba = 1'b0;
        step("rm_reset", 0, 4'h0, 2'b00, 1'b0);
        rst = 1'b0;
        for (int j = 0; j < 8; j++) step("rm_after", j, 4'hA, 2'b01, 1'b0);
        step("rm_alt", 0, 4'h3, 2'b10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
